// File: rtl/fp16_pkg.sv
// Shared fp16 divider definitions: field widths, exponent bias, FSM states.
package fp16_pkg;

  localparam int FP16_BIAS = 15;
  localparam int EXP_W     = 5;
  localparam int MANT_W    = 10;
  localparam int Q_W       = MANT_W + 2;
  localparam int REM_W     = MANT_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [15:0] fp16_pack(input logic s,
                                            input logic [EXP_W-1:0] e,
                                            input logic [MANT_W-1:0] m);
    return {s, e, m};
  endfunction

endpackage

// File: rtl/fp16_div_step.sv
// One radix-2 restoring division step: compare, conditionally subtract, shift.
module fp16_div_step
  import fp16_pkg::*;
(
  input  logic [REM_W-1:0]  rem_i,
  input  logic [MANT_W:0]   div_i,
  output logic [REM_W-1:0]  rem_o,
  output logic              q_o
);

  logic [REM_W-1:0] sel_s;

  // Partial remainder stays below 2*divisor, so the shifted result fits REM_W bits.
  always_comb begin
    q_o = (rem_i >= {1'b0, div_i});
    if (q_o) begin
      sel_s = rem_i - {1'b0, div_i};
    end else begin
      sel_s = rem_i;
    end
    rem_o = sel_s << 1;
  end

endmodule

// File: rtl/fp16_div.sv
// Multi-cycle fp16 divider (truncating, no special-value handling).
// Optional macro FP16_DIV_DBZ_EN adds a divide-by-zero flag and infinity result.
module fp16_div
  import fp16_pkg::*;
#(
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] c,
  output logic        busy
`ifdef FP16_DIV_DBZ_EN
  ,
  output logic        dbz
`endif
);

  localparam int N     = Q_W / ITER_PER_CYCLE;
  localparam int CNT_W = 4;

  state_e           state_q, state_d;
  logic [15:0]      a_q, a_d, b_q, b_d, c_q, c_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [Q_W-1:0]   quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
`ifdef FP16_DIV_DBZ_EN
  logic             dbz_q, dbz_d;
`endif

  logic [REM_W-1:0]          rem_chain_s [ITER_PER_CYCLE+1];
  logic [ITER_PER_CYCLE-1:0] qbit_s;
  logic [EXP_W-1:0]          exp_s;
  logic [MANT_W-1:0]         mant_s;
  logic                      sign_s;
  logic [15:0]               result_s;

  assign rem_chain_s[0] = rem_q;

  for (genvar i = 0; i < ITER_PER_CYCLE; i++) begin : g_step
    fp16_div_step u_step (
      .rem_i (rem_chain_s[i]),
      .div_i ({1'b1, b_q[MANT_W-1:0]}),
      .rem_o (rem_chain_s[i+1]),
      .q_o   (qbit_s[ITER_PER_CYCLE-1-i])
    );
  end

  // Normalisation of the quotient plus zero / divide-by-zero overrides.
  always_comb begin
    sign_s = a_q[15] ^ b_q[15];
    if (quo_q[Q_W-1]) begin
      exp_s  = a_q[14:10] - b_q[14:10] + EXP_W'(FP16_BIAS);
      mant_s = quo_q[Q_W-2:1];
    end else begin
      exp_s  = a_q[14:10] - b_q[14:10] + EXP_W'(FP16_BIAS - 1);
      mant_s = quo_q[MANT_W-1:0];
    end
    if (a_q == 16'h0000) begin
      result_s = 16'h0000;
    end else if (b_q == 16'h0000) begin
`ifdef FP16_DIV_DBZ_EN
      result_s = fp16_pack(sign_s, 5'h1F, 10'h000);
`else
      result_s = 16'h0000;
`endif
    end else begin
      result_s = fp16_pack(sign_s, exp_s, mant_s);
    end
  end

  // Next-state and datapath update for the IDLE -> DIV -> NORM -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = b;
          rem_d   = {1'b0, 1'b1, a[MANT_W-1:0]};
          quo_d   = 12'h000;
          cnt_d   = 4'd0;
          state_d = ST_DIV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DIV: begin
        rem_d = rem_chain_s[ITER_PER_CYCLE];
        quo_d = {quo_q[Q_W-1-ITER_PER_CYCLE:0], qbit_s};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = ST_NORM;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_NORM: begin
        c_d     = result_s;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // c was captured on entry to DONE; out_valid follows one cycle later.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
`ifdef FP16_DIV_DBZ_EN
    dbz_d      = out_valid_d && (b_q == 16'h0000);
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      c_q         <= 16'h0000;
      rem_q       <= 12'h000;
      quo_q       <= 12'h000;
      cnt_q       <= 4'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef FP16_DIV_DBZ_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
`ifdef FP16_DIV_DBZ_EN
      dbz_q       <= dbz_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign busy      = busy_q;
`ifdef FP16_DIV_DBZ_EN
  assign dbz       = dbz_q;
`endif

endmodule

// File: tb/tb_fp16_div.sv
// Directed bench for fp16_div: instance 0 resolves 1 bit/cycle, instance 1 resolves 2.
module tb_fp16_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [15:0] a         [2];
  logic [15:0] b         [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] c         [2];
  logic        busy      [2];
`ifdef FP16_DIV_DBZ_EN
  logic        dbz       [2];
  localparam logic [15:0] DBZ_RES = 16'h7C00;
`else
  localparam logic [15:0] DBZ_RES = 16'h0000;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp16_div #(.ITER_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .c(c[0]), .busy(busy[0])
`ifdef FP16_DIV_DBZ_EN
    , .dbz(dbz[0])
`endif
  );

  fp16_div #(.ITER_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .c(c[1]), .busy(busy[1])
`ifdef FP16_DIV_DBZ_EN
    , .dbz(dbz[1])
`endif
  );

  function automatic int exp_lat(input int d);
    return (d == 0) ? 14 : 8;
  endfunction

  task automatic start_op(input int d, input logic [15:0] av, input logic [15:0] bv);
    int w = 0;
    while (in_ready[d] !== 1'b1 && w < 40) begin
      @(posedge clk); #1; w++;
    end
    n_cmp++;
    if (in_ready[d] !== 1'b1) begin
      n_err++;
      $display("FAIL start_ready dut%0d: in_ready=%b required 1", d, in_ready[d]);
    end
    @(negedge clk);
    in_valid[d] = 1'b1; a[d] = av; b[d] = bv;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_valid(input int d, output int lat, output logic ready_seen);
    lat = 0; ready_seen = 1'b0;
    while (out_valid[d] !== 1'b1 && lat < 40) begin
      if (in_ready[d] !== 1'b0) ready_seen = 1'b1;
      @(posedge clk); #1; lat++;
    end
    if (in_ready[d] !== 1'b0) ready_seen = 1'b1;
  endtask

  task automatic handshake(input int d);
    @(negedge clk); out_ready[d] = 1'b1;
    @(posedge clk); #1; out_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (out_valid[d] !== 1'b0 || c[d] !== 16'h0000 || busy[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
        n_err++;
        $display("FAIL reset_state dut%0d: ov=%b c=%h busy=%b rdy=%b required 0 0000 0 1",
                 d, out_valid[d], c[d], busy[d], in_ready[d]);
      end
`ifdef FP16_DIV_DBZ_EN
      n_cmp++;
      if (dbz[d] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_dbz dut%0d: dbz=%b required 0", d, dbz[d]);
      end
`endif
    end
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    logic [15:0] va [10] = '{16'h3C00, 16'h4600, 16'h3C00, 16'hC000, 16'h0000,
                             16'h4000, 16'h3C00, 16'h3E00, 16'h4000, 16'h0000};
    logic [15:0] vb [10] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4000, 16'h4000,
                             16'h3C00, 16'h4000, 16'h3F00, 16'h0000, 16'h0000};
    logic [15:0] vc [10] = '{16'h3C00, 16'h4200, 16'h3555, 16'hBC00, 16'h0000,
                             16'h4000, 16'h3800, 16'h3ADB, DBZ_RES,  16'h0000};
    int   lat;
    logic rs;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 10; i++) begin
        start_op(d, va[i], vb[i]);
        wait_valid(d, lat, rs);
        n_cmp++;
        if (lat != exp_lat(d)) begin
          n_err++;
          $display("FAIL latency dut%0d %h/%h: got %0d required %0d", d, va[i], vb[i], lat, exp_lat(d));
        end
        n_cmp++;
        if (c[d] !== vc[i]) begin
          n_err++;
          $display("FAIL quotient dut%0d %h/%h: got %h required %h", d, va[i], vb[i], c[d], vc[i]);
        end
        n_cmp++;
        if (rs !== 1'b0 || busy[d] !== 1'b1) begin
          n_err++;
          $display("FAIL busy_window dut%0d %h/%h: ready_seen=%b busy=%b required 0 1", d, va[i], vb[i], rs, busy[d]);
        end
`ifdef FP16_DIV_DBZ_EN
        n_cmp++;
        if (dbz[d] !== (vb[i] == 16'h0000)) begin
          n_err++;
          $display("FAIL dbz_flag dut%0d %h/%h: got %b required %b", d, va[i], vb[i], dbz[d], vb[i] == 16'h0000);
        end
`endif
        handshake(d);
        n_cmp++;
        if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
          n_err++;
          $display("FAIL release dut%0d: rdy=%b ov=%b busy=%b required 1 0 0", d, in_ready[d], out_valid[d], busy[d]);
        end
      end
    end
  endtask

  task automatic test_stall();
    int   lat;
    logic rs;
    int   spurious = 0;
    start_op(0, 16'h3C00, 16'h3C00);
    wait_valid(0, lat, rs);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid[0] = 1'b1; a[0] = 16'h4600; b[0] = 16'h4000;
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid[0] !== 1'b1 || c[0] !== 16'h3C00 || in_ready[0] !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold cycle %0d: ov=%b c=%h rdy=%b required 1 3c00 0", k, out_valid[0], c[0], in_ready[0]);
      end
    end
    in_valid[0] = 1'b0;
    handshake(0);
    n_cmp++;
    if (in_ready[0] !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release: rdy=%b required 1", in_ready[0]);
    end
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) spurious++;
    end
    n_cmp++;
    if (spurious != 0) begin
      n_err++;
      $display("FAIL stall_ignored_input: %0d busy/valid cycles, required 0", spurious);
    end
  endtask

  task automatic test_reset_mid_div();
    int   lat;
    logic rs;
    int   spurious;
    for (int d = 0; d < 2; d++) begin
      spurious = 0;
      start_op(d, 16'h3C00, 16'h3C00);
      repeat (2) begin
        @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp++;
      if (busy[d] !== 1'b0 || in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0) begin
        n_err++;
        $display("FAIL mid_div_reset dut%0d: busy=%b rdy=%b ov=%b required 0 1 0", d, busy[d], in_ready[d], out_valid[d]);
      end
      repeat (20) begin
        @(posedge clk); #1;
        if (out_valid[d] !== 1'b0) spurious++;
      end
      n_cmp++;
      if (spurious != 0) begin
        n_err++;
        $display("FAIL mid_div_no_result dut%0d: %0d valid cycles, required 0", d, spurious);
      end
      start_op(d, 16'h4600, 16'h4000);
      wait_valid(d, lat, rs);
      n_cmp++;
      if (c[d] !== 16'h4200 || lat != exp_lat(d)) begin
        n_err++;
        $display("FAIL after_reset_op dut%0d: c=%h lat=%0d required 4200 %0d", d, c[d], lat, exp_lat(d));
      end
      handshake(d);
    end
  endtask

  task automatic test_reset_in_done();
    int   lat;
    logic rs;
    start_op(1, 16'h4000, 16'h3C00);
    wait_valid(1, lat, rs);
    @(negedge clk);
    rst = 1'b1; out_ready[1] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready[1] = 1'b0;
    n_cmp++;
    if (out_valid[1] !== 1'b0 || c[1] !== 16'h0000 || in_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
      n_err++;
      $display("FAIL done_reset: ov=%b c=%h rdy=%b busy=%b required 0 0000 1 0",
               out_valid[1], c[1], in_ready[1], busy[1]);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0; a[d] = 16'h0000; b[d] = 16'h0000;
    end
    test_reset();
    test_vectors();
    test_stall();
    test_reset_mid_div();
    test_reset_in_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp16_div.md
FP16_DIV -- requirements
Module: fp16_div

Interface
REQ-001 SHALL have parameter ITER_PER_CYCLE, default 1, quotient bits resolved per DIV cycle (legal: 1, 2).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operands a/b valid.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  16  dividend, fp16 {sign, exp[4:0], mant[9:0]}.
REQ-007 SHALL have port b  input  16  divisor, same format.
REQ-008 SHALL have port out_valid  output  1  result c valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts c.
REQ-010 SHALL have port c  output  16  quotient a/b, fp16.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM IDLE -> DIV -> NORM -> DONE -> IDLE.
REQ-013 SHALL drive in_ready high only in IDLE.
REQ-014 SHALL accept on in_valid && in_ready, register a and b, go to DIV.
REQ-015 SHALL stay in DIV for N = 12/ITER_PER_CYCLE cycles, using a radix-2 restoring divide of {1,a.mant} by {1,b.mant}.
REQ-016 Quotient SHALL be Q = floor({1,a.mant}*2^11 / {1,b.mant}), 12 bits.
REQ-017 NORM SHALL normalize in one cycle: if Q[11]=1, mant=Q[10:1] and exp=a.exp-b.exp+15; else mant=Q[9:0] and exp=a.exp-b.exp+14.
REQ-018 Exponent arithmetic SHALL be 5-bit modulo; no overflow, underflow, subnormal or rounding handling; truncation only.
REQ-019 c sign SHALL be a.sign XOR b.sign.
REQ-020 If a == 16'h0000, c SHALL be 16'h0000.
REQ-021 Zero-operand and divide-by-zero cases SHALL take the same fixed latency as normal operands.
REQ-022 out_valid SHALL rise exactly N+2 cycles after the accepting edge and stay high, with c stable, until out_valid && out_ready.
REQ-023 On the out_valid && out_ready edge, SHALL return to IDLE; in_ready SHALL rise the following cycle, with no same-cycle re-accept.
REQ-024 Inputs presented while busy SHALL be ignored.

Reset
REQ-025 rst SHALL force IDLE, out_valid=0, c=16'h0000, busy=0, and in_ready=1 on the next cycle.
REQ-026 rst asserted in any state, including mid-DIV or DONE, SHALL discard the operation and emit no result.
REQ-027 rst SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-028 Macro FP16_DIV_DBZ_EN defined: port dbz output 1 SHALL exist; b == 16'h0000 (a nonzero) SHALL give c={sign,5'h1F,10'h0}, and dbz SHALL be high while out_valid; 0/0 SHALL give 16'h0000 with dbz=1; dbz SHALL reset to 0.
REQ-029 Macro FP16_DIV_DBZ_EN undefined: no dbz port; b == 16'h0000 SHALL give c=16'h0000.

Structure
REQ-030 Shared package fp16_pkg SHALL hold FP16_BIAS=15, field widths (EXP_W=5, MANT_W=10), and the FSM state typedef.
REQ-031 One sub-module, fp16_div_step, SHALL perform a single restoring step (partial remainder, divisor -> next remainder, quotient bit) and be instantiated ITER_PER_CYCLE times.

Verification
REQ-032 a=3C00, b=3C00 -> c=3C00 after N+2 cycles; in_ready low throughout.
REQ-033 a=4600, b=4000 -> 4200; a=3C00, b=4200 -> 3555 (Q[11]=0 path, truncated).
REQ-034 a=C000, b=4000 -> BC00; a=0000, b=4000 -> 0000.
REQ-035 a=4000, b=0000 -> 7C00 with dbz=1 (macro defined); 0000 (macro undefined).
REQ-036 out_ready held low 5 cycles after out_valid -> c and out_valid stable, in_ready=0, and a new in_valid is ignored.
REQ-037 rst pulsed in the 3rd DIV cycle -> out_valid never rises; IDLE next cycle; a subsequent 4600/4000 still yields 4200; repeat with ITER_PER_CYCLE=2 (latency 8).
